mem_stage_lsu: RTL and testbench

- Parametrised successor to the pipeline data-memory stage. Adds byte addressing, LB/LH/LW/LBU/LHU/SB/SH/SW support, and misalignment detection.
- Sub-word stores are done as read-modify-write on a single-port, word-wide synchronous memory, with a pipeline stall.
- Sits between EX/MEM and MEM/WB. Also provides a burst testbench preloader and a sticky test-pass flag.

---
 rtl/mem_stage_lsu.sv | 217 +++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu
// Purpose  : Pipeline data-memory stage with byte addressing, sign/zero
//            extended sub-word loads, read-modify-write sub-word stores,
//            misalignment detection, burst preloader and sticky pass flag.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
    parameter int              ADDR_W  = 10,
    parameter logic [ADDR_W-1:0] OK_ADDR = 'h01C,
    parameter logic [31:0]     OK_DATA = 32'h0000_0002
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              EN,
    input  logic              START,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              tb_load_valid,
    input  logic              tb_load_first,
    input  logic [ADDR_W-1:0] tb_load_base,
    input  logic [31:0]       tb_load_data,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              req_err,
    output logic              OK
);

    localparam int         c_DEPTH  = 1 << ADDR_W;
    localparam logic [1:0] c_SIZE_B = 2'b00;
    localparam logic [1:0] c_SIZE_H = 2'b01;
    localparam logic [1:0] c_SIZE_W = 2'b10;
    localparam logic [1:0] c_SIZE_X = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [31:0]       r_mem [0:c_DEPTH-1];
    logic [31:0]       r_rdata;

    logic [ADDR_W-1:0] r_ptr;
    logic              r_ld_valid;
    logic [31:0]       r_ld_hold;
    logic              r_err;
    logic              r_ok;
    logic [1:0]        r_ld_size;
    logic [1:0]        r_ld_off;
    logic              r_ld_uns;
    logic [ADDR_W-1:0] r_st_idx;
    logic [1:0]        r_st_off;
    logic [1:0]        r_st_size;
    logic [15:0]       r_st_data;

    logic [ADDR_W-1:0] w_word_idx;
    logic [1:0]        w_off;
    logic              w_bad;
    logic              w_accept;
    logic              w_go;
    logic              w_ld_go;
    logic              w_sw_go;
    logic              w_rmw_go;
    logic              w_pre_go;
    logic              w_mem_we;
    logic              w_mem_re;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [31:0]       w_mem_wdata;
    logic [31:0]       w_merged;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_ld_ext;
    logic              w_unused_addr;

    // Address bits above the memory depth are deliberately ignored.
    assign w_unused_addr = ^req_addr[31:ADDR_W+2];

    assign w_word_idx = req_addr[ADDR_W+1:2];
    assign w_off      = req_addr[1:0];

    assign w_bad = (req_size == c_SIZE_X)
                 | ((req_size == c_SIZE_H) & w_off[0])
                 | ((req_size == c_SIZE_W) & (w_off != 2'b00));

    // Preload beats take priority; requests only enter from IDLE.
    assign w_accept = req_valid & EN & START & ~tb_load_valid & (r_state == ST_IDLE);
    assign w_go     = w_accept & ~w_bad;
    assign w_ld_go  = w_go & ~req_we;
    assign w_sw_go  = w_go & req_we & (req_size == c_SIZE_W);
    assign w_rmw_go = w_go & req_we & (req_size != c_SIZE_W);
    assign w_pre_go = tb_load_valid & (r_state == ST_IDLE);

    // Next state, stall and the single memory port arbitration.
    always_comb begin
        w_state_next = r_state;
        stall        = tb_load_valid;
        w_mem_we     = 1'b0;
        w_mem_re     = 1'b0;
        w_mem_addr   = w_word_idx;
        w_mem_wdata  = req_wdata;
        case (r_state)
            ST_IDLE: begin
                if (w_pre_go) begin
                    w_mem_we    = 1'b1;
                    w_mem_addr  = tb_load_first ? tb_load_base : r_ptr;
                    w_mem_wdata = tb_load_data;
                end else if (w_ld_go) begin
                    w_mem_re = 1'b1;
                end else if (w_sw_go) begin
                    w_mem_we = 1'b1;
                end else if (w_rmw_go) begin
                    w_mem_re     = 1'b1;
                    stall        = 1'b1;
                    w_state_next = ST_RMW_WR;
                end
            end
            ST_RMW_WR: begin
                // The pending merge write always wins over a preload beat.
                w_mem_we     = 1'b1;
                w_mem_addr   = r_st_idx;
                w_mem_wdata  = w_merged;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Insert the stored byte/half into the word read back from memory.
    always_comb begin
        w_merged = r_rdata;
        if (r_st_size == c_SIZE_B) begin
            w_merged[{r_st_off, 3'b000} +: 8] = r_st_data[7:0];
        end else begin
            w_merged[{r_st_off[1], 4'b0000} +: 16] = r_st_data;
        end
    end

    // Select and extend the load lane from the registered request fields.
    always_comb begin
        w_byte = r_rdata[{r_ld_off, 3'b000} +: 8];
        w_half = r_rdata[{r_ld_off[1], 4'b0000} +: 16];
        case (r_ld_size)
            c_SIZE_B: w_ld_ext = {{24{~r_ld_uns & w_byte[7]}}, w_byte};
            c_SIZE_H: w_ld_ext = {{16{~r_ld_uns & w_half[15]}}, w_half};
            default:  w_ld_ext = r_rdata;
        endcase
    end

    // Synchronous single-port memory; contents survive reset.
    always_ff @(posedge CLK) begin
        if (w_mem_we && RSTn) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
        if (w_mem_re) begin
            r_rdata <= r_mem[w_mem_addr];
        end
    end

    // Control state, load/store request capture, pointer and pass flag.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_ld_valid <= 1'b0;
            r_ld_hold  <= '0;
            r_err      <= 1'b0;
            r_ok       <= 1'b0;
            r_ld_size  <= '0;
            r_ld_off   <= '0;
            r_ld_uns   <= 1'b0;
            r_st_idx   <= '0;
            r_st_off   <= '0;
            r_st_size  <= '0;
            r_st_data  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ld_valid <= w_ld_go;
            r_err      <= w_accept & w_bad;
            if (r_ld_valid) begin
                r_ld_hold <= w_ld_ext;
            end
            if (w_ld_go) begin
                r_ld_size <= req_size;
                r_ld_off  <= w_off;
                r_ld_uns  <= req_unsigned;
            end
            if (w_rmw_go) begin
                r_st_idx  <= w_word_idx;
                r_st_off  <= w_off;
                r_st_size <= req_size;
                r_st_data <= req_wdata[15:0];
            end
            if (w_pre_go) begin
                r_ptr <= w_mem_addr + 1'b1;
            end
            if (w_mem_we && (w_mem_addr == OK_ADDR) && (w_mem_wdata == OK_DATA)) begin
                r_ok <= 1'b1;
            end
        end
    end

    assign load_valid = r_ld_valid;
    assign load_data  = r_ld_valid ? w_ld_ext : r_ld_hold;
    assign req_err    = r_err;
    assign OK         = r_ok;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_lsu
// Purpose  : Self-checking bench for mem_stage_lsu: transaction-level model
//            with per-cycle output comparison plus literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

    logic        CLK;
    logic        RSTn;
    logic        EN;
    logic        START;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        tb_load_valid;
    logic        tb_load_first;
    logic [9:0]  tb_load_base;
    logic [31:0] tb_load_data;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        req_err;
    logic        OK;

    mem_stage_lsu dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .EN           (EN),
        .START        (START),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .tb_load_valid(tb_load_valid),
        .tb_load_first(tb_load_first),
        .tb_load_base (tb_load_base),
        .tb_load_data (tb_load_data),
        .stall        (stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .req_err      (req_err),
        .OK           (OK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model state: memory image, preload pointer and expected outputs.
    logic [31:0] m_mem [0:1023];
    int          m_ptr;
    logic        exp_stall, exp_lv, exp_err, exp_ok;
    logic [31:0] exp_ld;
    logic        pend_lv, pend_err, pend_ok;
    logic [31:0] pend_ld;
    bit          chk_en;
    int          n_checks;
    int          n_errors;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            cmp("stall", {31'd0, stall}, {31'd0, exp_stall});
            cmp("load_valid", {31'd0, load_valid}, {31'd0, exp_lv});
            cmp("req_err", {31'd0, req_err}, {31'd0, exp_err});
            cmp("OK", {31'd0, OK}, {31'd0, exp_ok});
            cmp("load_data", load_data, exp_ld);
        end
    end

    function automatic bit m_bad(input logic [1:0] size, input int off);
        return (size == 2'b11) || (size == 2'b01 && (off % 2) == 1) || (size == 2'b10 && off != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] size,
                                           input int off, input bit uns);
        logic [31:0] v;
        v = w >> (8 * off);
        if (size == 2'b00) begin
            v = v & 32'h0000_00FF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = v & 32'h0000_FFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic m_write(input int idx, input logic [31:0] d);
        m_mem[idx] = d;
        if (idx == 'h1C && d == 32'h2) pend_ok = 1'b1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        exp_ok   = exp_ok | pend_ok;
        pend_ok  = 1'b0;
        exp_lv   = pend_lv;
        if (pend_lv) exp_ld = pend_ld;
        pend_lv  = 1'b0;
        exp_err  = pend_err;
        pend_err = 1'b0;
        req_valid     = 1'b0;
        tb_load_valid = 1'b0;
        tb_load_first = 1'b0;
        exp_stall     = 1'b0;
    endtask

    task automatic drive_req(input bit we, input logic [1:0] size, input bit uns,
                             input logic [31:0] addr, input logic [31:0] data);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = data;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input bit uns);
        int idx;
        int off;
        idx = int'(addr >> 2) & 1023;
        off = int'(addr & 3);
        drive_req(1'b0, size, uns, addr, 32'h0);
        if (EN && START) begin
            if (m_bad(size, off)) begin
                pend_err = 1'b1;
            end else begin
                pend_lv = 1'b1;
                pend_ld = m_load(m_mem[idx], size, off, uns);
            end
        end
        tick();
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
        int idx;
        int off;
        int nb;
        logic [31:0] merged;
        idx = int'(addr >> 2) & 1023;
        off = int'(addr & 3);
        drive_req(1'b1, size, 1'b0, addr, data);
        if (m_bad(size, off)) begin
            pend_err = 1'b1;
            tick();
        end else if (size == 2'b10) begin
            m_write(idx, data);
            tick();
        end else begin
            exp_stall = 1'b1;
            #1;
            cmp("rmw_stall_lit", {31'd0, stall}, 32'd1);
            tick();
            drive_req(1'b1, size, 1'b0, addr, data);
            merged = m_mem[idx];
            nb = (size == 2'b00) ? 1 : 2;
            for (int k = 0; k < nb; k++) begin
                merged[8 * (off + k) +: 8] = data[8 * k +: 8];
            end
            m_write(idx, merged);
            tick();
        end
    endtask

    task automatic preload_beat(input bit first, input logic [9:0] base, input logic [31:0] data);
        int a;
        tb_load_valid = 1'b1;
        tb_load_first = first;
        tb_load_base  = base;
        tb_load_data  = data;
        exp_stall     = 1'b1;
        a = first ? int'(base) : m_ptr;
        m_write(a, data);
        m_ptr = (a + 1) % 1024;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        n_checks = 0;
        n_errors = 0;
        chk_en = 1'b0;
        RSTn = 1'b0;
        EN = 1'b1;
        START = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        tb_load_valid = 1'b0; tb_load_first = 1'b0; tb_load_base = '0; tb_load_data = '0;
        exp_stall = 0; exp_lv = 0; exp_err = 0; exp_ok = 0; exp_ld = '0;
        pend_lv = 0; pend_err = 0; pend_ok = 0; pend_ld = '0;
        m_ptr = 0;

        tick();
        chk_en = 1'b1;
        tick();
        cmp("reset_ok_lit", {31'd0, OK}, 32'd0);
        cmp("reset_ld_lit", load_data, 32'd0);
        RSTn = 1'b1;
        tick();

        // Preload burst and readback
        preload_beat(1'b1, 10'h010, 32'hA0);
        preload_beat(1'b0, 10'h3AA, 32'hA1);
        preload_beat(1'b0, 10'h3AA, 32'hA2);
        preload_beat(1'b0, 10'h3AA, 32'hA3);
        do_load(32'h40, 2'b10, 1'b0); cmp("lw_a0_lit", load_data, 32'hA0);
        do_load(32'h44, 2'b10, 1'b0); cmp("lw_a1_lit", load_data, 32'hA1);
        do_load(32'h48, 2'b10, 1'b0); cmp("lw_a2_lit", load_data, 32'hA2);
        do_load(32'h4C, 2'b10, 1'b0); cmp("lw_a3_lit", load_data, 32'hA3);

        // Pointer wrap
        preload_beat(1'b1, 10'h3FF, 32'hB0);
        preload_beat(1'b0, 10'h000, 32'hB1);
        do_load(32'hFFC, 2'b10, 1'b0); cmp("wrap_top_lit", load_data, 32'hB0);
        do_load(32'h000, 2'b10, 1'b0); cmp("wrap_zero_lit", load_data, 32'hB1);

        // Sign / zero extension
        do_store(32'h100, 2'b10, 32'h8081_7F80);
        do_load(32'h100, 2'b00, 1'b0); cmp("lb_lit", load_data, 32'hFFFF_FF80);
        do_load(32'h100, 2'b00, 1'b1); cmp("lbu_lit", load_data, 32'h0000_0080);
        do_load(32'h102, 2'b01, 1'b0); cmp("lh_lit", load_data, 32'hFFFF_8081);
        do_load(32'h102, 2'b01, 1'b1); cmp("lhu_lit", load_data, 32'h0000_8081);

        // Byte store read-modify-write
        do_store(32'h100, 2'b10, 32'h1122_3344);
        do_store(32'h101, 2'b00, 32'hDEAD_BE55);
        do_load(32'h100, 2'b10, 1'b0); cmp("sb_lit", load_data, 32'h1122_5544);

        // Misaligned / illegal
        do_load(32'h101, 2'b01, 1'b0); cmp("err_lh_lit", {31'd0, req_err}, 32'd1);
        do_store(32'h102, 2'b10, 32'hFFFF_FFFF); cmp("err_sw_lit", {31'd0, req_err}, 32'd1);
        do_load(32'h100, 2'b11, 1'b0); cmp("err_x_lit", {31'd0, req_err}, 32'd1);
        do_load(32'h100, 2'b10, 1'b0); cmp("err_nochg_lit", load_data, 32'h1122_5544);

        // Requests ignored while the core is not running
        START = 1'b0;
        do_load(32'h100, 2'b10, 1'b0); cmp("nostart_lit", {31'd0, load_valid}, 32'd0);
        START = 1'b1;

        // Pass flag
        do_store(32'h70, 2'b10, 32'h3);
        tick(); tick();
        cmp("ok_wrong_lit", {31'd0, OK}, 32'd0);
        do_store(32'h70, 2'b10, 32'h2);
        cmp("ok_set_lit", {31'd0, OK}, 32'd1);
        tick(); tick(); tick();
        cmp("ok_sticky_lit", {31'd0, OK}, 32'd1);

        // Reset during RMW_WR of a half store
        do_store(32'h200, 2'b10, 32'h1111_1111);
        drive_req(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_BEEF);
        exp_stall = 1'b1;
        tick();
        drive_req(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_BEEF);
        RSTn = 1'b0;
        req_valid = 1'b0;
        exp_stall = 0; exp_ok = 0; exp_lv = 0; exp_err = 0; exp_ld = '0;
        pend_lv = 0; pend_err = 0; pend_ok = 0;
        m_ptr = 0;
        #1;
        cmp("rst_stall_lit", {31'd0, stall}, 32'd0);
        cmp("rst_ok_lit", {31'd0, OK}, 32'd0);
        tick();
        RSTn = 1'b1;
        preload_beat(1'b0, 10'h155, 32'hC0);
        do_load(32'h000, 2'b10, 1'b0); cmp("ptr_rst_lit", load_data, 32'hC0);
        do_load(32'h200, 2'b10, 1'b0); cmp("rst_nochg_lit", load_data, 32'h1111_1111);

        // Preload beat arriving during RMW_WR
        drive_req(1'b1, 2'b01, 1'b0, 32'h200, 32'h0000_CAFE);
        exp_stall = 1'b1;
        tick();
        drive_req(1'b1, 2'b01, 1'b0, 32'h200, 32'h0000_CAFE);
        tb_load_valid = 1'b1;
        tb_load_first = 1'b1;
        tb_load_base  = 10'h2A0;
        tb_load_data  = 32'h1234_5678;
        exp_stall     = 1'b1;
        w = m_mem['h80];
        w[15:0] = 16'hCAFE;
        m_write('h80, w);
        tick();
        preload_beat(1'b1, 10'h2A0, 32'h1234_5678);
        do_load(32'h200, 2'b10, 1'b0); cmp("rmw_first_lit", load_data, 32'h1111_CAFE);
        do_load(32'hA80, 2'b10, 1'b0); cmp("beat_after_lit", load_data, 32'h1234_5678);

        tick(); tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
